sync_frame_transmitter: RTL

- Bit-serial transmitter that sends framed bytes on a single-wire stream.
- Frame = fixed sync pattern, then data word MSB-first, then optional parity bit, then idle gap bits.
- Producer side of the serial sync-pattern link; the pattern-detecting receiver on the far end locks onto the sync field.
- Valid/ready input handshake; bit rate set by an external bit-enable strobe.

---
 rtl/sync_frame_transmitter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sync_frame_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : sync_frame_transmitter
// Description : Bit-serial framed transmitter. Each accepted word is sent as
//               sync pattern (MSB-first), data word (MSB-first), optional
//               even-parity bit, then GAP_LEN idle bits at logic 1. The stream
//               advances one bit per clock edge that has bit_en=1.
//               Optional feature macro: SYNC_TX_PARITY_EN (adds parity bit).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_frame_transmitter #(
    parameter int                  SYNC_LEN     = 7,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 7'b0110110,
    parameter int                  DATA_W       = 8,
    parameter int                  GAP_LEN      = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              bit_en,
    output logic              out_bit,
    output logic              out_active,
    output logic              frame_done,
    output logic              busy
);

    // Counter covers the longest field; it only ever counts down to zero.
    localparam int MAX_SD  = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
    localparam int MAX_LEN = (MAX_SD > GAP_LEN) ? MAX_SD : GAP_LEN;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0] C_SYNC_INIT = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] C_DATA_INIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] C_GAP_INIT  = (GAP_LEN == 0) ? '0 : CNT_W'(GAP_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                out_bit_q, out_bit_d;
    logic                out_active_q, out_active_d;
    logic                frame_done_q, frame_done_d;
`ifdef SYNC_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    logic                w_sync_bit;
    logic                w_last;

    // Next sync bit to present: pattern bit (cnt_q - 1), selected with a mask.
    assign w_sync_bit = |(SYNC_PATTERN & (SYNC_LEN'(1) << (cnt_q - CNT_W'(1))));

    assign tx_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign out_bit    = out_bit_q;
    assign out_active = out_active_q;
    assign frame_done = frame_done_q;

    // Next-state and output logic; everything holds unless accepting or bit_en.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        out_bit_d    = out_bit_q;
        out_active_d = out_active_q;
        frame_done_d = 1'b0;
        w_last       = 1'b0;
`ifdef SYNC_TX_PARITY_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    state_d      = S_SYNC;
                    shift_d      = tx_data;
                    out_bit_d    = SYNC_PATTERN[SYNC_LEN-1];
                    out_active_d = 1'b1;
                    cnt_d        = C_SYNC_INIT;
`ifdef SYNC_TX_PARITY_EN
                    parity_d     = ^tx_data;
`endif
                end
            end
            S_SYNC: begin
                if (bit_en) begin
                    if (cnt_q == '0) begin
                        state_d   = S_DATA;
                        out_bit_d = shift_q[DATA_W-1];
                        shift_d   = shift_q << 1;
                        cnt_d     = C_DATA_INIT;
                    end else begin
                        out_bit_d = w_sync_bit;
                        cnt_d     = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (bit_en) begin
                    if (cnt_q == '0) begin
`ifdef SYNC_TX_PARITY_EN
                        state_d   = S_PARITY;
                        out_bit_d = parity_q;
`else
                        w_last    = 1'b1;
`endif
                    end else begin
                        out_bit_d = shift_q[DATA_W-1];
                        shift_d   = shift_q << 1;
                        cnt_d     = cnt_q - CNT_W'(1);
                    end
                end
            end
`ifdef SYNC_TX_PARITY_EN
            S_PARITY: begin
                if (bit_en) begin
                    w_last = 1'b1;
                end
            end
`endif
            S_GAP: begin
                if (bit_en) begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Leaving the final data/parity bit: pulse done and drop to idle level.
        if (w_last) begin
            frame_done_d = 1'b1;
            out_bit_d    = 1'b1;
            out_active_d = 1'b0;
            cnt_d        = C_GAP_INIT;
            state_d      = (GAP_LEN == 0) ? S_IDLE : S_GAP;
        end
    end

    // State and output registers with asynchronous reset to idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            out_bit_q    <= 1'b1;
            out_active_q <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef SYNC_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            out_bit_q    <= out_bit_d;
            out_active_q <= out_active_d;
            frame_done_q <= frame_done_d;
`ifdef SYNC_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

endmodule
`default_nettype wire
